// File: rtl/brush_settings_ctrl.sv
// Brush size/symmetry settings from raw buttons: synchronise, debounce, size auto-repeat on hold.
// Raw press to output register is DEBOUNCE_CYCLES+3 clocks; no backpressure, outputs are plain registers.
module brush_settings_ctrl #(
    parameter int SIZE_W          = 3,
    parameter int SIZE_MAX        = 7,
    parameter int SIZE_RESET      = 0,
    parameter int SYM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_size_up,
    input  logic              btn_size_down,
    input  logic              btn_symmetry,
    output logic [SIZE_W-1:0] brush_size,
    output logic [1:0]        symmetry_mode,
    output logic              at_min,
    output logic              at_max,
    output logic              settings_changed
);
    localparam int NB   = 3;
    localparam int UP   = 0;
    localparam int DN   = 1;
    localparam int SYM  = 2;
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [NB-1:0] raw, sync1, sync2, stable, stable_q, lock, press;
    logic [DW-1:0] deb_cnt [NB];
    logic [1:0]    prime;

    logic [RW-1:0] rep_cnt;
    logic          rep_run, rep_up, rep_ok, rep_fire;
    logic          hold_up, hold_dn, up_hit, dn_hit, step_up, step_dn;
    logic [SIZE_W-1:0] size_nxt;
    logic [1:0]        mode_nxt;

    assign raw = {btn_symmetry, btn_size_down, btn_size_up};

    // lock blocks a press from a button still held through reset; it clears on the first
    // real synchronised low sample (prime marks when sync2 holds a post-reset sample)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            lock     <= '1;
            press    <= '0;
            prime    <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            prime    <= {prime[0], 1'b1};
            press    <= stable & ~stable_q & ~lock;
            for (int i = 0; i < NB; i++) begin
                if (prime[1] && !sync2[i])
                    lock[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign hold_up = stable[UP] & ~stable[DN];
    assign hold_dn = stable[DN] & ~stable[UP];
    assign up_hit  = press[UP] & ~press[DN] & ~stable[DN];
    assign dn_hit  = press[DN] & ~press[UP] & ~stable[UP];
    assign rep_ok  = rep_up ? hold_up : hold_dn;

    // rep_cnt counts clocks since the last step; zero means repeat is disarmed
    assign rep_fire = (REPEAT_DELAY != 0) && (rep_cnt != '0) && rep_ok &&
                      (rep_run ? (rep_cnt == RW'(REPEAT_RATE)) : (rep_cnt == RW'(REPEAT_DELAY)));
    assign step_up  = up_hit | (rep_fire & rep_up);
    assign step_dn  = dn_hit | (rep_fire & ~rep_up);

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
            rep_up  <= 1'b0;
        end else if (up_hit || dn_hit) begin
            rep_cnt <= ((REPEAT_DELAY != 0) && (up_hit ? hold_up : hold_dn)) ? RW'(1) : '0;
            rep_run <= 1'b0;
            rep_up  <= up_hit;
        end else if (!rep_ok) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt <= RW'(1);
            rep_run <= 1'b1;
        end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    always_comb begin
        size_nxt = brush_size;
        mode_nxt = symmetry_mode;
        if (step_up && !step_dn) begin
            if (brush_size != SIZE_W'(SIZE_MAX))
                size_nxt = brush_size + 1'b1;
        end else if (step_dn && !step_up) begin
            if (brush_size != '0)
                size_nxt = brush_size - 1'b1;
        end
        if (press[SYM])
            mode_nxt = (symmetry_mode == 2'(SYM_MODES - 1)) ? 2'd0 : symmetry_mode + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brush_size       <= SIZE_W'(SIZE_RESET);
            symmetry_mode    <= 2'd0;
            settings_changed <= 1'b0;
        end else begin
            brush_size       <= size_nxt;
            symmetry_mode    <= mode_nxt;
            settings_changed <= (size_nxt != brush_size) || (mode_nxt != symmetry_mode);
        end
    end

    assign at_min = (brush_size == '0);
    assign at_max = (brush_size == SIZE_W'(SIZE_MAX));
endmodule

// File: tb/tb_brush_settings_ctrl.sv
// Bench for brush_settings_ctrl: edge-indexed behavioural model checked every cycle,
// plus hand-computed checkpoints on a 4-mode and a 2-mode instance sharing the same buttons.
module tb_brush_settings_ctrl;
    localparam int D    = 4;
    localparam int RD   = 16;
    localparam int RR   = 4;
    localparam int SMAX = 7;
    localparam int HN   = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_size_up = 1'b0, btn_size_down = 1'b0, btn_symmetry = 1'b0;
    logic [2:0] brush_size, brush_size2;
    logic [1:0] symmetry_mode, symmetry_mode2;
    logic       at_min, at_max, settings_changed;
    logic       at_min2, at_max2, settings_changed2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    brush_settings_ctrl #(.SIZE_W(3), .SIZE_MAX(SMAX), .SIZE_RESET(0), .SYM_MODES(4),
                          .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst(rst), .btn_size_up(btn_size_up), .btn_size_down(btn_size_down),
        .btn_symmetry(btn_symmetry), .brush_size(brush_size), .symmetry_mode(symmetry_mode),
        .at_min(at_min), .at_max(at_max), .settings_changed(settings_changed));

    brush_settings_ctrl #(.SIZE_W(3), .SIZE_MAX(SMAX), .SIZE_RESET(0), .SYM_MODES(2),
                          .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut2 (
        .clk(clk), .rst(rst), .btn_size_up(btn_size_up), .btn_size_down(btn_size_down),
        .btn_symmetry(btn_symmetry), .brush_size(brush_size2), .symmetry_mode(symmetry_mode2),
        .at_min(at_min2), .at_max(at_max2), .settings_changed(settings_changed2));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state after each rising edge n; samples are indexed by edge number.
    bit smp [3][0:HN-1];
    bit real_smp [0:HN-1];
    bit deb [3];
    bit lock [3];
    int rise_at [3] = '{-100, -100, -100};
    int origin = -1;
    bit org_up = 1'b0;
    int n = 0;
    int m_size = 0, m_mode = 0, m_mode2 = 0;
    bit m_chg = 1'b0, m_chg2 = 1'b0;

    always @(posedge clk) begin : model
        bit raw [3];
        bit press [3];
        bit hold_up, hold_dn, up_hit, dn_hit, fire, su, sd, all_opp;
        int ns, nm, nm2;
        raw[0] = btn_size_up;
        raw[1] = btn_size_down;
        raw[2] = btn_symmetry;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                smp[b][n] = 1'b0;
                deb[b]    = 1'b0;
                lock[b]   = 1'b1;
                rise_at[b] = -100;
            end
            real_smp[n] = 1'b0;
            origin = -1;
            m_size = 0; m_mode = 0; m_mode2 = 0;
            m_chg = 1'b0; m_chg2 = 1'b0;
        end else begin
            for (int b = 0; b < 3; b++) smp[b][n] = raw[b];
            real_smp[n] = 1'b1;
            // a debounced rise becomes a step two edges later
            for (int b = 0; b < 3; b++) press[b] = (rise_at[b] == n - 2);
            hold_up = deb[0] && !deb[1];
            hold_dn = deb[1] && !deb[0];
            up_hit  = press[0] && !press[1] && !deb[1];
            dn_hit  = press[1] && !press[0] && !deb[0];
            fire = 1'b0;
            if (origin >= 0) begin
                if (!(org_up ? hold_up : hold_dn)) origin = -1;
                else if (n - origin >= RD && (n - origin - RD) % RR == 0) fire = 1'b1;
            end
            su = up_hit || (fire && org_up);
            sd = dn_hit || (fire && !org_up);
            if (up_hit || dn_hit) begin
                origin = (up_hit ? hold_up : hold_dn) ? n : -1;
                org_up = up_hit;
            end
            ns = m_size;
            if (su && !sd) ns = (m_size < SMAX) ? m_size + 1 : m_size;
            else if (sd && !su) ns = (m_size > 0) ? m_size - 1 : 0;
            nm  = press[2] ? (m_mode + 1) % 4 : m_mode;
            nm2 = press[2] ? (m_mode2 + 1) % 2 : m_mode2;
            m_chg  = (ns != m_size) || (nm != m_mode);
            m_chg2 = (ns != m_size) || (nm2 != m_mode2);
            m_size = ns; m_mode = nm; m_mode2 = nm2;
            for (int b = 0; b < 3; b++) begin
                if (n >= 2 && real_smp[n-2] && !smp[b][n-2]) lock[b] = 1'b0;
                all_opp = 1'b1;
                for (int k = 0; k < D; k++)
                    if (n - 2 - k < 0 || smp[b][n-2-k] == deb[b]) all_opp = 1'b0;
                if (all_opp) begin
                    deb[b] = !deb[b];
                    if (deb[b] && !lock[b]) rise_at[b] = n;
                end
            end
        end
        n++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("brush_size",        brush_size,        m_size);
            chk("symmetry_mode",     symmetry_mode,     m_mode);
            chk("at_min",            at_min,            (m_size == 0) ? 1 : 0);
            chk("at_max",            at_max,            (m_size == SMAX) ? 1 : 0);
            chk("settings_changed",  settings_changed,  m_chg ? 1 : 0);
            chk("brush_size2",       brush_size2,       m_size);
            chk("symmetry_mode2",    symmetry_mode2,    m_mode2);
            chk("at_min2",           at_min2,           (m_size == 0) ? 1 : 0);
            chk("at_max2",           at_max2,           (m_size == SMAX) ? 1 : 0);
            chk("settings_changed2", settings_changed2, m_chg2 ? 1 : 0);
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic press_btn(input int which, input int hold, input int idle);
        if (which == 0) btn_size_up = 1'b1;
        else if (which == 1) btn_size_down = 1'b1;
        else btn_symmetry = 1'b1;
        step(hold);
        btn_size_up = 1'b0; btn_size_down = 1'b0; btn_symmetry = 1'b0;
        step(idle);
    endtask

    int e4 [5] = '{1, 2, 3, 0, 1};
    int e2 [5] = '{1, 0, 1, 0, 1};

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        step(3);
        chk("rst_size", brush_size, 0);
        chk("rst_mode", symmetry_mode, 0);
        chk("rst_at_min", at_min, 1);
        chk("rst_at_max", at_max, 0);
        chk("rst_changed", settings_changed, 0);
        rst = 1'b0;
        step(8);

        press_btn(0, 3, 12);
        chk("glitch_size", brush_size, 0);

        btn_size_up = 1'b1;
        step(7);
        chk("deb_edge6_size", brush_size, 0);
        step(1);
        chk("deb_edge7_size", brush_size, 1);
        chk("deb_edge7_changed", settings_changed, 1);
        step(1);
        chk("deb_edge8_changed", settings_changed, 0);
        step(1);
        btn_size_up = 1'b0;
        step(12);

        press_btn(1, 10, 12);
        chk("down_to_0", brush_size, 0);
        press_btn(1, 10, 12);
        chk("sat_down_size", brush_size, 0);
        chk("sat_down_at_min", at_min, 1);

        btn_size_up = 1'b1;
        step(23);
        chk("rep_edge22_size", brush_size, 1);
        step(1);
        chk("rep_edge23_size", brush_size, 2);
        step(4);
        chk("rep_edge27_size", brush_size, 3);
        step(32);
        chk("rep_sat_size", brush_size, 7);
        chk("rep_sat_at_max", at_max, 1);
        btn_size_up = 1'b0;
        step(12);

        for (int i = 0; i < 4; i++) press_btn(1, 10, 10);
        chk("down_to_3", brush_size, 3);

        btn_size_up = 1'b1;
        btn_size_down = 1'b1;
        step(12);
        btn_size_up = 1'b0;
        btn_size_down = 1'b0;
        step(12);
        chk("both_size", brush_size, 3);

        btn_size_up = 1'b1;
        step(10);
        chk("held_up_size", brush_size, 4);
        btn_size_down = 1'b1;
        step(40);
        chk("repeat_blocked_size", brush_size, 4);
        btn_size_up = 1'b0;
        btn_size_down = 1'b0;
        step(12);
        chk("after_block_size", brush_size, 4);

        for (int i = 0; i < 5; i++) begin
            press_btn(2, 8, 10);
            chk("sym4_wrap", symmetry_mode, e4[i]);
            chk("sym2_wrap", symmetry_mode2, e2[i]);
        end

        btn_symmetry = 1'b1;
        step(10);
        rst = 1'b1;
        step(2);
        chk("rst_mid_mode", symmetry_mode, 0);
        chk("rst_mid_size", brush_size, 0);
        chk("rst_mid_changed", settings_changed, 0);
        rst = 1'b0;
        step(20);
        chk("held_thru_rst_mode", symmetry_mode, 0);
        chk("held_thru_rst_mode2", symmetry_mode2, 0);
        btn_symmetry = 1'b0;
        step(10);
        press_btn(2, 8, 10);
        chk("repress_mode", symmetry_mode, 1);
        chk("repress_mode2", symmetry_mode2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
